// File: rtl/sram_lsu_ctrl.sv
// Splits one 32-bit LSU access into two 16-bit phases on an async SRAM.
// Optional `SRAM_CTRL_WSKIP_EN: skip write phases whose two byte enables are both 0.
module sram_lsu_ctrl #(
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned ACC_CYC = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_bmask,
    output logic              o_ready,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic [ADDR_W-1:0] o_sram_addr,
    inout  wire  [15:0]       io_sram_dq,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n
);
    localparam int unsigned     CNT_W = (ACC_CYC > 2) ? $clog2(ACC_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-2:0] r_addr, w_addr;
    logic [31:0]       r_wdata, w_wdata;
    logic [3:0]        r_bmask, w_bmask;
    logic              r_we, w_we;
    logic              w_accept, w_last, w_hi, w_skip_lo, w_skip_hi;
    logic [15:0]       r_rd_lo;
    logic              w_unused_bits;

    logic              r_ce_n, r_oe_n, r_we_n, r_lb_n, r_ub_n, r_dq_oe, r_done;
    logic              w_ce_n, w_oe_n, w_we_n, w_lb_n, w_ub_n, w_dq_oe;
    logic [ADDR_W-1:0] r_sram_addr, w_sram_addr;
    logic [15:0]       r_dq_out, w_dq_out;
    logic [31:0]       r_rdata;

    assign w_accept      = (r_state == S_IDLE) && i_req;
    assign w_addr        = w_accept ? i_addr[ADDR_W:2] : r_addr;
    assign w_wdata       = w_accept ? i_wdata : r_wdata;
    assign w_bmask       = w_accept ? i_bmask : r_bmask;
    assign w_we          = w_accept ? i_we : r_we;
    assign w_last        = (r_cnt == LAST);
    assign w_hi          = (w_state_nxt == S_HI);
    assign w_unused_bits = ^{i_addr[31:ADDR_W+1], i_addr[1:0]};

`ifdef SRAM_CTRL_WSKIP_EN
    assign w_skip_lo = w_we && (w_bmask[1:0] == 2'b00);
    assign w_skip_hi = w_we && (w_bmask[3:2] == 2'b00);
`else
    assign w_skip_lo = 1'b0;
    assign w_skip_hi = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt = '0;
                    if (w_skip_lo) w_state_nxt = w_skip_hi ? S_DONE : S_HI;
                    else           w_state_nxt = S_LO;
                end
            end
            S_LO: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_skip_hi ? S_DONE : S_HI;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_HI: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pins are registered, so they are derived from the next state/phase cycle.
    always_comb begin
        w_ce_n      = 1'b1;
        w_oe_n      = 1'b1;
        w_we_n      = 1'b1;
        w_lb_n      = 1'b1;
        w_ub_n      = 1'b1;
        w_dq_oe     = 1'b0;
        w_dq_out    = r_dq_out;
        w_sram_addr = r_sram_addr;
        if (w_state_nxt == S_LO || w_state_nxt == S_HI) begin
            w_ce_n      = 1'b0;
            w_sram_addr = {w_addr, w_hi};
            if (w_we) begin
                w_we_n   = (w_cnt_nxt == '0);
                w_dq_oe  = 1'b1;
                w_dq_out = w_hi ? w_wdata[31:16] : w_wdata[15:0];
                w_lb_n   = ~(w_hi ? w_bmask[2] : w_bmask[0]);
                w_ub_n   = ~(w_hi ? w_bmask[3] : w_bmask[1]);
            end else begin
                w_oe_n = 1'b0;
                w_lb_n = 1'b0;
                w_ub_n = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_bmask     <= '0;
            r_we        <= 1'b0;
            r_rd_lo     <= '0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= '0;
            r_sram_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
                r_bmask <= w_bmask;
                r_we    <= w_we;
            end
            if (r_state == S_LO && w_last && !r_we) r_rd_lo <= io_sram_dq;
            if (r_state == S_HI && w_last && !r_we) r_rdata <= {io_sram_dq, r_rd_lo};
            r_done      <= (w_state_nxt == S_DONE);
            r_ce_n      <= w_ce_n;
            r_oe_n      <= w_oe_n;
            r_we_n      <= w_we_n;
            r_lb_n      <= w_lb_n;
            r_ub_n      <= w_ub_n;
            r_dq_oe     <= w_dq_oe;
            r_dq_out    <= w_dq_out;
            r_sram_addr <= w_sram_addr;
        end
    end

    assign io_sram_dq  = r_dq_oe ? r_dq_out : 'z;
    assign o_ready     = (r_state == S_IDLE);
    assign o_done      = r_done;
    assign o_rdata     = r_rdata;
    assign o_sram_addr = r_sram_addr;
    assign o_sram_ce_n = r_ce_n;
    assign o_sram_oe_n = r_oe_n;
    assign o_sram_we_n = r_we_n;
    assign o_sram_lb_n = r_lb_n;
    assign o_sram_ub_n = r_ub_n;
endmodule

// File: tb/tb_sram_lsu_ctrl.sv
// Scoreboard bench for sram_lsu_ctrl with a cycle-level async SRAM model.
module tb_sram_lsu_ctrl;
    localparam int unsigned ACC = 2;

    logic        clk = 1'b0, rstn = 1'b0, req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  bmask = '0;
    logic        ready, done, ce_n, oe_n, we_n, lb_n, ub_n;
    logic [31:0] rdata;
    logic [17:0] saddr;
    wire  [15:0] sdq;

    logic [15:0] mem [0:262143];
    int unsigned cyc = 0, n_assert = 0, n_fail = 0, n_done = 0, n_exp = 0;

    typedef struct { int unsigned cyc; logic [31:0] rdata; } exp_t;
    exp_t q[$];
    exp_t e;

    sram_lsu_ctrl #(.ADDR_W(18), .ACC_CYC(ACC)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .i_bmask(bmask), .o_ready(ready), .o_done(done),
        .o_rdata(rdata), .o_sram_addr(saddr), .io_sram_dq(sdq),
        .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
        .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: drives DQ on reads, captures bytes at a clock edge while we_n is low.
    assign sdq = (!ce_n && !oe_n && we_n) ? mem[saddr] : 'z;
    always @(posedge clk) begin
        if (cyc == 0) begin
            mem[18'h200] <= 16'hBEEF;
            mem[18'h201] <= 16'hDEAD;
        end else if (!ce_n && !we_n) begin
            if (!lb_n) mem[saddr][7:0]  <= sdq[7:0];
            if (!ub_n) mem[saddr][15:8] <= sdq[15:8];
        end
    end

    always @(negedge clk) begin
        if (!ce_n && !oe_n) begin
            n_assert++;
            if (sdq !== mem[saddr] || !we_n) begin
                n_fail++;
                $display("FAIL read_bus: dq=%h we_n=%b, need dq=%h we_n=1", sdq, we_n, mem[saddr]);
            end
        end
        if (done) begin
            n_done++;
            if (q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_done: o_done=1 at cyc %0d, need no done", cyc);
            end else begin
                e = q.pop_front();
                n_assert += 2;
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL done_cycle: got %0d need %0d", cyc, e.cyc);
                end
                if (rdata !== e.rdata) begin
                    n_fail++;
                    $display("FAIL rdata: got %h need %h", rdata, e.rdata);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] need);
        n_assert++;
        if (got !== need) begin
            n_fail++;
            $display("FAIL %s: got %h need %h at cyc %0d", name, got, need, cyc);
        end
    endtask

    task automatic chk_pins(input string name, input logic [17:0] a,
                            input logic c, input logic o, input logic w, input logic l, input logic u);
        chk(name, {9'b0, saddr, ce_n, oe_n, we_n, lb_n, ub_n}, {9'b0, a, c, o, w, l, u});
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic [31:0] exp_rd, input int unsigned lat,
                         input bit push, input bit hold, input int unsigned fixed_done,
                         output int unsigned k);
        int unsigned n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'b0, ready}, 32'd1);
        we = w; addr = a; wdata = d; bmask = m; req = 1'b1;
        k = cyc + 1;
        if (push) begin
            q.push_back('{(fixed_done != 0) ? fixed_done : k + lat, exp_rd});
            n_exp++;
        end
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, need $finish earlier");
        $fatal(1);
    end

    initial begin
        int unsigned k, k1, k2;
        repeat (3) @(negedge clk);
        chk_pins("reset_pins", 18'h0, 1, 1, 1, 1, 1);
        chk("reset_ready", {31'b0, ready}, 32'd1);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_rdata", rdata, 32'h0);
        rstn = 1'b1;

        // T1: reset during HI phase of a write
        issue(1'b1, 32'h40C, 32'h11112222, 4'hF, 32'h0, 2*ACC, 1'b0, 1'b0, 0, k);
        repeat (3) @(negedge clk);
        chk_pins("t1_hi_pins", 18'h207, 0, 1, 1, 0, 0);
        #2 rstn = 1'b0;
        #1;
        chk_pins("t1_abort_pins", 18'h0, 1, 1, 1, 1, 1);
        chk("t1_abort_ready", {31'b0, ready}, 32'd1);
        chk("t1_abort_done", {31'b0, done}, 32'd0);
        @(negedge clk) rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_ready_after", {31'b0, ready}, 32'd1);
        chk("t1_lo_written", {16'b0, mem[18'h206]}, 32'h2222);

        // T2: read 0x400
        issue(1'b0, 32'h400, 32'h0, 4'hF, 32'hDEADBEEF, 2*ACC, 1'b1, 1'b0, 0, k);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_pins("t2_pins", 18'h200 + 18'(i / 2), 0, 0, 1, 0, 0);
        end
        drain("t2_drain");

        // T3: full write
        issue(1'b1, 32'h404, 32'h12345678, 4'hF, 32'hDEADBEEF, 2*ACC, 1'b1, 1'b0, 0, k);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_pins("t3_pins", 18'h202 + 18'(i / 2), 0, 1, (i % 2 == 0), 0, 0);
        end
        drain("t3_drain");
        chk("t3_mem_lo", {16'b0, mem[18'h202]}, 32'h5678);
        chk("t3_mem_hi", {16'b0, mem[18'h203]}, 32'h1234);

        // T4: single byte write
`ifdef SRAM_CTRL_WSKIP_EN
        issue(1'b1, 32'h404, 32'hAABBCCDD, 4'b0100, 32'hDEADBEEF, ACC, 1'b1, 1'b0, 0, k);
`else
        issue(1'b1, 32'h404, 32'hAABBCCDD, 4'b0100, 32'hDEADBEEF, 2*ACC, 1'b1, 1'b0, 0, k);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_pins("t4_pins", 18'h202 + 18'(i / 2), 0, 1, (i % 2 == 0), (i < 2), 1);
        end
`endif
        drain("t4_drain");
        chk("t4_mem_lo", {16'b0, mem[18'h202]}, 32'h5678);
        chk("t4_mem_hi", {16'b0, mem[18'h203]}, 32'h12BB);

        // T5: back-to-back write then read with i_req held
        issue(1'b1, 32'h408, 32'hCAFEF00D, 4'hF, 32'hDEADBEEF, 2*ACC, 1'b1, 1'b1, 0, k1);
        issue(1'b0, 32'h408, 32'h0, 4'hF, 32'hCAFEF00D, 2*ACC, 1'b1, 1'b0, k1 + 4*ACC + 2, k2);
        chk("t5_second_accept", k2, k1 + 2*ACC + 2);
        drain("t5_drain");

        // T6: request pulse mid-access is ignored
        issue(1'b0, 32'h400, 32'h0, 4'hF, 32'hDEADBEEF, 2*ACC, 1'b1, 1'b0, 0, k);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_pins("t6_pins", 18'h200 + 18'(i / 2), 0, 0, 1, 0, 0);
            if (i == 0) begin
                req = 1'b1; addr = 32'h800; we = 1'b1;
            end
            if (i == 1) req = 1'b0;
        end
        drain("t6_drain");
        repeat (10) @(negedge clk);
        chk("final_queue", q.size(), 32'd0);
        chk("final_done_count", n_done, n_exp);
        chk("final_ready", {31'b0, ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
